// File: rtl/menu_index_fetch.sv
// Menu screen pixel-index fetch: scrolled image-ROM addressing plus a 3-stage palette-index pipeline.
// Optional MENU_FETCH_PAUSE_EN enables the IDLE/RUN/HOLD pause control through scroll_en.
module menu_index_fetch #(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              vsync,
  input  logic              scroll_en,
  input  logic [3:0]        scroll_speed,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pal_index,
  output logic              pix_valid,
  output logic [8:0]        scroll_pos
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
`ifdef MENU_FETCH_PAUSE_EN
    , HOLD = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        offset_q, offset_d;
  logic [3:0]        speed_q, speed_d;
  logic              vsync_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_d1_q, valid_d2_q;
  logic [3:0]        pal_q;
  logic              pix_valid_q;

  logic              frame_tick;
  logic [9:0]        step_sum;
  logic [8:0]        offset_adv;
  logic [9:0]        ix, iy;
  logic [10:0]       x_sum, x_wrap;
  logic              in_img;

`ifndef MENU_FETCH_PAUSE_EN
  logic unused_scroll_en;
  assign unused_scroll_en = scroll_en;
`endif

  assign frame_tick = vsync_q & ~vsync;

  // Offset wraps modulo the image width so it never leaves 0..IMG_W-1.
  assign step_sum   = {1'b0, offset_q} + {6'd0, speed_q};
  assign offset_adv = (step_sum >= 10'(IMG_W)) ? 9'(step_sum - 10'(IMG_W)) : step_sum[8:0];

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    speed_d  = speed_q;
    if (frame_tick) begin
      speed_d = scroll_speed;
      case (state_q)
`ifdef MENU_FETCH_PAUSE_EN
        IDLE: state_d = scroll_en ? RUN : HOLD;
        RUN: begin
          if (scroll_en) offset_d = offset_adv;
          else           state_d  = HOLD;
        end
        HOLD: begin
          if (scroll_en) state_d = RUN;
        end
`else
        IDLE: state_d = RUN;
        RUN:  offset_d = offset_adv;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  assign ix     = DrawX >> SCALE_SHIFT;
  assign iy     = DrawY >> SCALE_SHIFT;
  assign x_sum  = {1'b0, ix} + {2'd0, offset_q};
  assign x_wrap = (x_sum >= 11'(IMG_W)) ? (x_sum - 11'(IMG_W)) : x_sum;
  assign in_img = blank & (ix < 10'(IMG_W)) & (iy < 10'(IMG_H));

  always_comb begin
    addr_d = '0;
    if (in_img) addr_d = ADDR_W'(iy) * ADDR_W'(IMG_W) + ADDR_W'(x_wrap);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      offset_q    <= '0;
      speed_q     <= '0;
      vsync_q     <= 1'b1;
      addr_q      <= '0;
      valid_d1_q  <= 1'b0;
      valid_d2_q  <= 1'b0;
      pal_q       <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      speed_q     <= speed_d;
      vsync_q     <= vsync;
      addr_q      <= addr_d;
      valid_d1_q  <= in_img;
      valid_d2_q  <= valid_d1_q;
      pal_q       <= valid_d2_q ? rom_q : 4'd0;
      pix_valid_q <= valid_d2_q;
    end
  end

  assign rom_addr   = addr_q;
  assign pal_index  = pal_q;
  assign pix_valid  = pix_valid_q;
  assign scroll_pos = offset_q;

endmodule

// File: tb/tb_menu_index_fetch.sv
// Directed self-checking bench for menu_index_fetch with a synchronous ROM model (data = addr[3:0] ^ 7).
module tb_menu_index_fetch;

  logic        Clk;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, vsync, scroll_en;
  logic [3:0]  scroll_speed;
  logic [16:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  pal_index;
  logic        pix_valid;
  logic [8:0]  scroll_pos;

  int checks = 0;
  int errors = 0;

  menu_index_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .vsync(vsync), .scroll_en(scroll_en), .scroll_speed(scroll_speed),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pix_valid(pix_valid), .scroll_pos(scroll_pos)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always_ff @(posedge Clk) rom_q <= rom_addr[3:0] ^ 4'h7;

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic b, input logic [9:0] x, input logic [9:0] y);
    blank = b;
    DrawX = x;
    DrawY = y;
  endtask

  task automatic frameTick(input logic [3:0] speed, input logic en);
    scroll_speed = speed;
    scroll_en    = en;
    vsync        = 1'b0;
    cycle();
    vsync        = 1'b1;
    cycle();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    scroll_en = 1'b1;
    scroll_speed = 4'd0;
    vsync = 1'b1;
    applyStimulus(1'b0, 10'd0, 10'd0);
    repeat (3) cycle();
    checkOutput("rst_addr", 32'(rom_addr), 32'd0);
    checkOutput("rst_pal", 32'(pal_index), 32'd0);
    checkOutput("rst_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_pos", 32'(scroll_pos), 32'd0);

    // First pixel after reset: address after 1 cycle, index after 3.
    applyStimulus(1'b1, 10'd0, 10'd0);
    Reset_n = 1'b1;
    cycle();
    checkOutput("first_addr", 32'(rom_addr), 32'd0);
    cycle();
    checkOutput("first_valid_c2", 32'(pix_valid), 32'd0);
    cycle();
    checkOutput("first_pal", 32'(pal_index), 32'd7);
    checkOutput("first_valid", 32'(pix_valid), 32'd1);

    frameTick(4'd3, 1'b1);
    checkOutput("pos_tick1", 32'(scroll_pos), 32'd0);
    frameTick(4'd3, 1'b1);
    frameTick(4'd3, 1'b1);
    checkOutput("pos_tick3", 32'(scroll_pos), 32'd6);
    applyStimulus(1'b1, 10'd2, 10'd4);
    cycle();
    checkOutput("addr_647", 32'(rom_addr), 32'd647);
    cycle();
    cycle();
    checkOutput("pal_647", 32'(pal_index), 32'd0);
    checkOutput("valid_647", 32'(pix_valid), 32'd1);

    // Walk the offset up to 318 with speed_q = 5, then wrap to 3.
    frameTick(4'd15, 1'b1);
    checkOutput("pos_9", 32'(scroll_pos), 32'd9);
    for (int i = 0; i < 19; i++) frameTick(4'd15, 1'b1);
    checkOutput("pos_294", 32'(scroll_pos), 32'd294);
    frameTick(4'd9, 1'b1);
    frameTick(4'd5, 1'b1);
    checkOutput("pos_318", 32'(scroll_pos), 32'd318);
    frameTick(4'd5, 1'b1);
    checkOutput("pos_wrap", 32'(scroll_pos), 32'd3);
    applyStimulus(1'b1, 10'd638, 10'd0);
    cycle();
    checkOutput("addr_xwrap", 32'(rom_addr), 32'd2);
    cycle();
    cycle();
    checkOutput("pal_xwrap", 32'(pal_index), 32'd5);
    checkOutput("valid_xwrap", 32'(pix_valid), 32'd1);

    applyStimulus(1'b1, 10'd10, 10'd478);
    cycle();
    checkOutput("addr_lastrow", 32'(rom_addr), 32'd76488);
    cycle();
    cycle();
    checkOutput("pal_lastrow", 32'(pal_index), 32'd15);

    applyStimulus(1'b1, 10'd640, 10'd0);
    cycle();
    checkOutput("addr_ix320", 32'(rom_addr), 32'd0);
    cycle();
    cycle();
    checkOutput("valid_ix320", 32'(pix_valid), 32'd0);

    applyStimulus(1'b0, 10'd10, 10'd10);
    cycle();
    checkOutput("addr_blank", 32'(rom_addr), 32'd0);
    cycle();
    cycle();
    checkOutput("valid_blank", 32'(pix_valid), 32'd0);
    checkOutput("pal_blank", 32'(pal_index), 32'd0);

    applyStimulus(1'b1, 10'd10, 10'd480);
    cycle();
    checkOutput("addr_iy240", 32'(rom_addr), 32'd0);
    cycle();
    cycle();
    checkOutput("valid_iy240", 32'(pix_valid), 32'd0);
    checkOutput("pal_iy240", 32'(pal_index), 32'd0);

    // Drop scroll_en for four frames, then raise it for two.
    for (int i = 0; i < 4; i++) frameTick(4'd5, 1'b0);
`ifdef MENU_FETCH_PAUSE_EN
    checkOutput("pos_paused", 32'(scroll_pos), 32'd3);
`else
    checkOutput("pos_paused", 32'(scroll_pos), 32'd23);
`endif
    frameTick(4'd5, 1'b1);
`ifdef MENU_FETCH_PAUSE_EN
    checkOutput("pos_resume1", 32'(scroll_pos), 32'd3);
`else
    checkOutput("pos_resume1", 32'(scroll_pos), 32'd28);
`endif
    frameTick(4'd5, 1'b1);
`ifdef MENU_FETCH_PAUSE_EN
    checkOutput("pos_resume2", 32'(scroll_pos), 32'd8);
`else
    checkOutput("pos_resume2", 32'(scroll_pos), 32'd33);
`endif

    applyStimulus(1'b1, 10'd4, 10'd2);
    repeat (3) cycle();
    checkOutput("valid_pre_rst", 32'(pix_valid), 32'd1);
    Reset_n = 1'b0;
    cycle();
    checkOutput("midrst_valid", 32'(pix_valid), 32'd0);
    checkOutput("midrst_pal", 32'(pal_index), 32'd0);
    checkOutput("midrst_pos", 32'(scroll_pos), 32'd0);
    checkOutput("midrst_addr", 32'(rom_addr), 32'd0);
    Reset_n = 1'b1;
    frameTick(4'd5, 1'b1);
    checkOutput("post_rst_tick1", 32'(scroll_pos), 32'd0);
    frameTick(4'd5, 1'b1);
    checkOutput("post_rst_tick2", 32'(scroll_pos), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
